nco_mc: RTL

Multi-channel numerically controlled oscillator producing NUM_CH independent quadrature (I/Q) tone pairs from one shared clock. Each channel has its own phase accumulator, frequency word and phase offset. Frequency and offset words are staged through a shadow-register configuration port and committed atomically across all channels on a sample boundary. The block sits between the control register bank and the modulator/mixer datapath, as the next-generation replacement for the single-channel `nco`.

---
 rtl/nco_mc.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/nco_mc.sv
// nco_mc: multi-channel quadrature NCO. Per-channel frequency/offset words are staged
// in shadow registers and committed together on a sample boundary; 3-stage output pipeline.
module nco_mc #(
    parameter int NUM_CH         = 4,
    parameter int LUT_ADDR_BITS  = 8,
    parameter int LUT_DATA_BITS  = 8,
    parameter int PHASE_ACC_BITS = 24,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                sync,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [CH_W-1:0]                     cfg_ch,
    input  logic [PHASE_ACC_BITS-1:0]           cfg_inc,
    input  logic [PHASE_ACC_BITS-1:0]           cfg_ofs,
    input  logic                                update_req,
    output logic                                out_valid,
    output logic [NUM_CH*(LUT_DATA_BITS+1)-1:0] out_i,
    output logic [NUM_CH*(LUT_DATA_BITS+1)-1:0] out_q
);
    localparam int A     = LUT_ADDR_BITS;
    localparam int D     = LUT_DATA_BITS;
    localparam int P     = PHASE_ACC_BITS;
    localparam int OW    = D + 1;
    localparam int PH_W  = A + 2;
    localparam int LO_W  = P - PH_W;
    localparam int LUT_N = 1 << A;

    typedef enum logic {S_IDLE, S_PEND} state_t;

    function automatic logic [D-1:0] lut_entry(input int idx);
        real x;
        real v;
        x = 3.14159265358979323846 / 2.0 * (real'(idx) + 0.5) / real'(LUT_N);
        v = real'((1 << D) - 1) * $sin(x);
        return D'($rtoi(v + 0.5));
    endfunction

    // Returns {I, Q} for one quadrant-folded sample; negation is exact two's complement.
    function automatic logic [2*OW-1:0] map_iq(input logic [1:0] q,
                                               input logic [D-1:0] s,
                                               input logic [D-1:0] m);
        logic signed [OW-1:0] ps;
        logic signed [OW-1:0] pm;
        ps = signed'({1'b0, s});
        pm = signed'({1'b0, m});
        case (q)
            2'd0:    return {pm, ps};
            2'd1:    return {-ps, pm};
            2'd2:    return {-pm, -ps};
            default: return {ps, -pm};
        endcase
    endfunction

    logic [D-1:0]      w_lut   [LUT_N];
    logic [PH_W-1:0]   w_ph    [NUM_CH];
    logic [2*OW-1:0]   w_iq    [NUM_CH];
    logic              w_wr;
    logic              w_commit;

    state_t            r_state;
    logic              r_cfg_ready;
    logic [P-1:0]      r_acc    [NUM_CH];
    logic [P-1:0]      r_inc    [NUM_CH];
    logic [P-1:0]      r_ofs    [NUM_CH];
    logic [P-1:0]      r_sh_inc [NUM_CH];
    logic [P-1:0]      r_sh_ofs [NUM_CH];
    logic              r_vld_p0, r_vld_p1, r_vld_p2;
    logic [PH_W-1:0]   r_ph_p0  [NUM_CH];
    logic [1:0]        r_q_p1   [NUM_CH];
    logic [D-1:0]      r_s_p1   [NUM_CH];
    logic [D-1:0]      r_m_p1   [NUM_CH];
    logic [NUM_CH*OW-1:0] r_out_i_p2, r_out_q_p2;

    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
        localparam logic [D-1:0] LV = lut_entry(gi);
        assign w_lut[gi] = LV;
    end

    // Only the top A+2 phase bits are kept; the truncated low half contributes just its carry,
    // and acc_lo + ofs_lo overflows exactly when acc_lo > ~ofs_lo.
    for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
        if (LO_W > 0) begin : g_carry
            assign w_ph[gc] = r_acc[gc][P-1 -: PH_W] + r_ofs[gc][P-1 -: PH_W]
                            + PH_W'(r_acc[gc][LO_W-1:0] > ~r_ofs[gc][LO_W-1:0]);
        end else begin : g_nocarry
            assign w_ph[gc] = r_acc[gc] + r_ofs[gc];
        end
        assign w_iq[gc] = map_iq(r_q_p1[gc], r_s_p1[gc], r_m_p1[gc]);
    end

    assign w_wr      = cfg_valid && r_cfg_ready;
    assign w_commit  = (r_state == S_PEND) && en;
    assign cfg_ready = r_cfg_ready;
    assign out_valid = r_vld_p2;
    assign out_i     = r_out_i_p2;
    assign out_q     = r_out_q_p2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cfg_ready <= 1'b1;
            r_vld_p0    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
        end else begin
            r_vld_p0 <= en;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
            case (r_state)
                S_IDLE: if (update_req) begin
                    r_state     <= S_PEND;
                    r_cfg_ready <= 1'b0;
                end
                default: if (en) begin
                    r_state     <= S_IDLE;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc[c]    <= '0;
                r_inc[c]    <= '0;
                r_ofs[c]    <= '0;
                r_sh_inc[c] <= '0;
                r_sh_ofs[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (sync)
                    r_acc[c] <= '0;
                else if (en)
                    r_acc[c] <= r_acc[c] + r_inc[c];
                if (w_wr && cfg_ch == CH_W'(c)) begin
                    r_sh_inc[c] <= cfg_inc;
                    r_sh_ofs[c] <= cfg_ofs;
                end
                if (w_commit) begin
                    r_inc[c] <= r_sh_inc[c];
                    r_ofs[c] <= r_sh_ofs[c];
                end
            end
        end
    end

    // Stage p0: phase sum; stage p1: ROM read of both quarter-wave addresses.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (en)
                r_ph_p0[c] <= w_ph[c];
            r_q_p1[c] <= r_ph_p0[c][PH_W-1 -: 2];
            r_s_p1[c] <= w_lut[r_ph_p0[c][A-1:0]];
            r_m_p1[c] <= w_lut[~r_ph_p0[c][A-1:0]];
        end
    end

    // Stage p2: quadrant mapping; outputs hold between valid samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_i_p2 <= '0;
            r_out_q_p2 <= '0;
        end else if (r_vld_p1) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_out_i_p2[c*OW +: OW] <= w_iq[c][2*OW-1 -: OW];
                r_out_q_p2[c*OW +: OW] <= w_iq[c][OW-1:0];
            end
        end
    end

endmodule
